// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display scheduler: active-low
// segment patterns (a in bit 0 ... g in bit 6), FSM states and digit count.
package seg_display_pkg;

    localparam logic [0:6] SEG0      = 7'b0000001;
    localparam logic [0:6] SEG1      = 7'b1001111;
    localparam logic [0:6] SEG2      = 7'b0010010;
    localparam logic [0:6] SEG3      = 7'b0000110;
    localparam logic [0:6] SEG4      = 7'b1001100;
    localparam logic [0:6] SEG5      = 7'b0100100;
    localparam logic [0:6] SEG6      = 7'b0100000;
    localparam logic [0:6] SEG7      = 7'b0001111;
    localparam logic [0:6] SEG8      = 7'b0000000;
    localparam logic [0:6] SEG9      = 7'b0001100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam int BCD_DIGITS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module bcd_to_seg7
    import seg_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [0:6] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG0;
            4'd1:    seg = SEG1;
            4'd2:    seg = SEG2;
            4'd3:    seg = SEG3;
            4'd4:    seg = SEG4;
            4'd5:    seg = SEG5;
            4'd6:    seg = SEG6;
            4'd7:    seg = SEG7;
            4'd8:    seg = SEG8;
            4'd9:    seg = SEG9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Round-robin sharing of the HEX7..HEX4 bank between two BCD requesters;
// each accepted word is held for DWELL_CYCLES before the next grant.
module hex_display_scheduler
    import seg_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        REQ0_VALID,
    input  logic [15:0] REQ0_DATA,
    output logic        REQ0_READY,
    input  logic        REQ1_VALID,
    input  logic [15:0] REQ1_DATA,
    output logic        REQ1_READY,
    output logic        OWNER,
    output logic        BUSY,
    output logic [0:6]  HEX7,
    output logic [0:6]  HEX6,
    output logic [0:6]  HEX5,
    output logic [0:6]  HEX4
);

    // A dwell of one cycle still needs a one-bit counter.
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [15:0]      disp_q, disp_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grant;
    logic [0:6]       seg [BCD_DIGITS];

    // Arbiter: on a tie the requester not served last wins (bit 0 = req 0).
    always_comb begin
        grant = 2'b00;
        if ((state_q == IDLE) && !RESET) begin
            if (REQ0_VALID && REQ1_VALID) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = {REQ1_VALID, REQ0_VALID};
            end
        end else begin
            grant = 2'b00;
        end
    end

    assign REQ0_READY = grant[0];
    assign REQ1_READY = grant[1];

    // Next-state logic: accept on grant, then count the dwell down to zero
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    disp_d  = grant[1] ? REQ1_DATA : REQ0_DATA;
                    owner_d = grant[1];
                    last_d  = grant[1];
                    cnt_d   = CNT_LOAD;
                    state_d = SHOW;
                end else begin
                    state_d = IDLE;
                end
            end
            SHOW: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            disp_q  <= 16'hFFFF;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
        bcd_to_seg7 u_dec (
            .bcd (disp_q[4*i +: 4]),
            .seg (seg[i])
        );
    end

    assign HEX4  = seg[0];
    assign HEX5  = seg[1];
    assign HEX6  = seg[2];
    assign HEX7  = seg[3];
    assign OWNER = owner_q;
    assign BUSY  = (state_q == SHOW);

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Scoreboard bench: a cycle-level model predicts every handshake; a monitor
// checks handshakes, held display, OWNER and BUSY each cycle.
module tb_hex_display_scheduler;

    localparam int D = 4;

    logic        clk;
    logic        RESET;
    logic        REQ0_VALID, REQ1_VALID;
    logic [15:0] REQ0_DATA, REQ1_DATA;
    logic        REQ0_READY, REQ1_READY;
    logic        OWNER, BUSY;
    logic [0:6]  HEX7, HEX6, HEX5, HEX4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic        src;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    hex_display_scheduler #(.DWELL_CYCLES(D)) dut (
        .CLOCK_50   (clk),
        .RESET      (RESET),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_DATA  (REQ0_DATA),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_DATA  (REQ1_DATA),
        .REQ1_READY (REQ1_READY),
        .OWNER      (OWNER),
        .BUSY       (BUSY),
        .HEX7       (HEX7),
        .HEX6       (HEX6),
        .HEX5       (HEX5),
        .HEX4       (HEX4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the display is free from cycle next_free onward; a
    // request in a free cycle is accepted, ties going to the one not served last.
    int   next_free = 0;
    logic last_src  = 1'b1;

    task automatic drive(input logic v0, input logic [15:0] d0,
                         input logic v1, input logic [15:0] d1, input logic rst);
        exp_t e;
        @(posedge clk);
        #1;
        RESET = rst;
        REQ0_VALID = v0; REQ0_DATA = d0;
        REQ1_VALID = v1; REQ1_DATA = d1;
        if (rst) begin
            next_free = cyc + 1;
            last_src  = 1'b1;
        end else if (cyc >= next_free && (v0 || v1)) begin
            e.cyc  = cyc;
            e.src  = (v0 && v1) ? !last_src : v1;
            e.data = e.src ? d1 : d0;
            sb.push_back(e);
            last_src  = e.src;
            next_free = cyc + D + 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    // Monitor: checks outputs each cycle and matches handshakes to the scoreboard
    initial begin : monitor
        logic [15:0] exp_disp;
        logic        exp_owner;
        int          busy_left;
        logic        prev_rst, pend, pend_src;
        logic [15:0] pend_data;
        exp_t        e;
        exp_disp = 16'hFFFF; exp_owner = 1'b0; busy_left = 0;
        prev_rst = 1'b1; pend = 1'b0; pend_src = 1'b0; pend_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                exp_disp = 16'hFFFF; exp_owner = 1'b0; busy_left = 0;
            end
            if (pend) begin
                exp_disp = pend_data; exp_owner = pend_src; busy_left = D;
                pend = 1'b0;
            end
            chk("busy", 16'(BUSY), 16'(busy_left > 0));
            chk("owner", 16'(OWNER), 16'(exp_owner));
            chk("hex7", 16'(HEX7), 16'(seg_of(exp_disp[15:12])));
            chk("hex6", 16'(HEX6), 16'(seg_of(exp_disp[11:8])));
            chk("hex5", 16'(HEX5), 16'(seg_of(exp_disp[7:4])));
            chk("hex4", 16'(HEX4), 16'(seg_of(exp_disp[3:0])));
            if (busy_left > 0) busy_left--;
            if (RESET) chk("ready_in_reset", 16'({REQ1_READY, REQ0_READY}), 16'h0000);
            chk("ready_onehot", 16'(REQ0_READY & REQ1_READY), 16'h0000);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missed_handshake_cycle", 16'(cyc), 16'(e.cyc));
            end
            if ((REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_handshake", 16'h0001, 16'h0000);
                end else begin
                    e = sb.pop_front();
                    chk("handshake_cycle", 16'(cyc), 16'(e.cyc));
                    chk("handshake_src", 16'(REQ1_VALID && REQ1_READY), 16'(e.src));
                    pend = 1'b1; pend_src = e.src; pend_data = e.data;
                end
            end
            prev_rst = RESET;
        end
    end

    initial begin : stimulus
        RESET = 1'b1;
        REQ0_VALID = 1'b0; REQ0_DATA = 16'h0000;
        REQ1_VALID = 1'b0; REQ1_DATA = 16'h0000;

        // Reset with requests present: nothing may be accepted
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 16'h5555, 1'b1, 16'h6666, 1'b1);
        chk("rst_ready0", 16'(REQ0_READY), 16'h0000);
        chk("rst_ready1", 16'(REQ1_READY), 16'h0000);
        idle(2);
        chk("rst_hex7", 16'(HEX7), 16'h007F);
        chk("rst_hex4", 16'(HEX4), 16'h007F);
        chk("rst_busy", 16'(BUSY), 16'h0000);
        chk("rst_owner", 16'(OWNER), 16'h0000);

        // Single requester, 16'h1234
        drive(1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0);
        chk("r0_ready_same_cycle", 16'(REQ0_READY), 16'h0001);
        idle(1);
        chk("h1234_hex7", 16'(HEX7), 16'b1001111);
        chk("h1234_hex6", 16'(HEX6), 16'b0010010);
        chk("h1234_hex5", 16'(HEX5), 16'b0000110);
        chk("h1234_hex4", 16'(HEX4), 16'b1001100);
        chk("h1234_busy", 16'(BUSY), 16'h0001);
        chk("h1234_ready_low_in_show", 16'(REQ0_READY), 16'h0000);
        idle(3);
        drive(1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0);
        chk("r0_ready_after_dwell", 16'(REQ0_READY), 16'h0001);
        idle(6);

        // Both held continuously after reset: alternating grants from requester 0
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0);
        chk("tie_first_r0", 16'(REQ0_READY), 16'h0001);
        for (int i = 0; i < 20; i++) drive(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0);
        idle(6);

        // Non-decimal nibbles blank
        drive(1'b0, 16'h0000, 1'b1, 16'h9AF0, 1'b0);
        idle(1);
        chk("h9af0_hex7", 16'(HEX7), 16'b0001100);
        chk("h9af0_hex6", 16'(HEX6), 16'b1111111);
        chk("h9af0_hex5", 16'(HEX5), 16'b1111111);
        chk("h9af0_hex4", 16'(HEX4), 16'b0000001);
        chk("h9af0_owner", 16'(OWNER), 16'h0001);
        idle(5);

        // Reset on the second SHOW cycle aborts the dwell
        drive(1'b0, 16'h0000, 1'b1, 16'h4321, 1'b0);
        idle(1);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 16'h7777, 1'b1, 16'h8888, 1'b0);
        chk("abort_hex7", 16'(HEX7), 16'h007F);
        chk("abort_busy", 16'(BUSY), 16'h0000);
        chk("abort_tie_r0", 16'(REQ0_READY), 16'h0001);
        chk("abort_tie_r1", 16'(REQ1_READY), 16'h0000);
        idle(6);

        // One-cycle VALID pulse during SHOW is ignored; display held after dwell
        drive(1'b1, 16'h0560, 1'b0, 16'h0000, 1'b0);
        idle(1);
        drive(1'b0, 16'h0000, 1'b1, 16'h3333, 1'b0);
        idle(8);
        chk("held_hex6", 16'(HEX6), 16'b0100100);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 59) == 0));
        end
        idle(8);
        chk("scoreboard_empty", 16'(sb.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
